writeback_arbiter: RTL

Shares the single CDB broadcast port between all write-back producers: the RS ALU result, the LSB load result, and any later execution units. Each source gets a small FIFO, so a one-cycle producer pulse is never lost. Heads are granted round-robin, one broadcast per cycle, and the block drives the CDB that feeds the ROB, RS and LSB wake-up logic. Its src_full backpressure is what the RS and LSB fold into their own full/issue-stall logic.

---
 rtl/writeback_arbiter_pkg.sv | 17 +
 rtl/writeback_arbiter_if.sv | 26 ++
 rtl/writeback_arbiter_wb_src_fifo.sv | 54 +++++
 rtl/writeback_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and helpers for the CDB write-back arbiter.
// Source indices name the producers feeding the broadcast port.
package writeback_arbiter_pkg;

  localparam int ROB_INDEX_BIT = 5;
  localparam int WB_SRC_NUM    = 3;
  localparam int WB_FIFO_DEPTH = 2;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSB = 1;
  localparam int WB_SRC_AUX = 2;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer-to-CDB bundle: per-source pulses in, backpressure
// and the registered broadcast out.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int N_SRC   = WB_SRC_NUM,
  parameter int ROB_BIT = ROB_INDEX_BIT
);
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC*ROB_BIT-1:0] src_rob_id;
  logic [N_SRC*32-1:0]      src_val;
  logic [N_SRC-1:0]         src_full;
  logic                     cdb_req;
  logic [ROB_BIT-1:0]       cdb_rob_id;
  logic [31:0]              cdb_val;

  modport master (
    output src_valid, src_rob_id, src_val,
    input  src_full, cdb_req, cdb_rob_id, cdb_val
  );

  modport slave (
    input  src_valid, src_rob_id, src_val,
    output src_full, cdb_req, cdb_rob_id, cdb_val
  );
endinterface

// File: rtl/writeback_arbiter_wb_src_fifo.sv
// Single-source write-back FIFO; a full FIFO still accepts
// a push when its head is popped in the same cycle.
module wb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_acc;
  logic          w_wr;

  assign w_acc   = i_push && (r_cnt < (AW+1)'(DEPTH) || i_pop);
  assign o_drop  = i_push && !w_acc;
  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign w_wr    = i_rst_n && !i_flush && i_en && w_acc;

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_acc)
        r_wp <= r_wp + 1'b1;
      if (i_pop)
        r_rp <= r_rp + 1'b1;
      if (w_acc && !i_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_acc && i_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the single CDB port between
// write-back sources, each buffered by its own small FIFO.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int N_SRC      = WB_SRC_NUM,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int ROB_BIT    = ROB_INDEX_BIT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  writeback_arbiter_if.slave wb,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int W  = ROB_BIT + 32;

  logic [AW:0]      w_cnt  [N_SRC];
  logic [W-1:0]     w_head [N_SRC];
  logic [N_SRC-1:0] w_pop;
  logic [N_SRC-1:0] w_drop;
  logic             w_gnt_vld;
  logic [IW-1:0]    w_gnt_idx;
  logic [W-1:0]     w_sel;

  logic             r_req;
  logic [ROB_BIT-1:0] r_rob;
  logic [31:0]      r_val;
  logic [IW-1:0]    r_rr;
  logic             r_ovf;

  for (genvar g = 0; g < N_SRC; g++) begin : g_fifo
    wb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (W)
    ) u_fifo (
      .i_clk   (clk_in),
      .i_rst_n (rst_in),
      .i_en    (rdy_in),
      .i_flush (clear),
      .i_push  (wb.src_valid[g]),
      .i_pop   (w_pop[g]),
      .i_din   ({wb.src_rob_id[g*ROB_BIT +: ROB_BIT],
                 wb.src_val[g*32 +: 32]}),
      .o_dout  (w_head[g]),
      .o_count (w_cnt[g]),
      .o_drop  (w_drop[g])
    );
    assign wb.src_full[g] =
      w_cnt[g] >= (AW+1)'(FIFO_DEPTH - 1);
    assign w_pop[g] =
      w_gnt_vld && (w_gnt_idx == IW'(g));
  end

  // Scan upward from r_rr, wrapping; first non-empty head wins.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(r_rr) + k;
      if (j >= N_SRC)
        j = j - N_SRC;
      if (!w_gnt_vld && w_cnt[j] != '0) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IW'(j);
      end
    end
  end

  assign w_sel = w_head[w_gnt_idx];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_req <= 1'b0;
      r_rob <= '0;
      r_val <= '0;
      r_rr  <= '0;
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_req <= 1'b0;
      r_rob <= '0;
      r_val <= '0;
      r_rr  <= '0;
    end else if (rdy_in) begin
      r_req <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_rob <= w_sel[W-1 -: ROB_BIT];
        r_val <= w_sel[31:0];
        r_rr  <= IW'(wrap_inc(int'(w_gnt_idx), N_SRC));
      end
      if (|w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign wb.cdb_req    = r_req;
  assign wb.cdb_rob_id = r_rob;
  assign wb.cdb_val    = r_val;
  assign overflow      = r_ovf;
endmodule
